i1_ctrl_initiator: RTL and testbench
====================================

# i1_ctrl_initiator

Sequential initiator for the i1 control interface. Accepts commands over valid/ready, buffers them, and drives the request lines of the combinational i1 control responder: request enable, 7-bit line mask, 2-bit mode and state bit. It samples the responder's hold/busy/grant outputs, re-samples while busy up to a timeout, and returns each outcome as a result record. It sits between the command sequencer and the i1 decode block, and is its initiating end.

## Interface
Parameters:
- FIFO_DEPTH, 4: command buffer entries; power of two, ≥2.
- SETTLE, 1: cycles between driving the request and the first sample; range 1–7.
- TIMEOUT, 15: maximum busy re-samples before forced completion; range 1–255.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO not full.
- cmd_mask  in  7  request lines 1..7; 0 means no line requested.
- cmd_mode  in  2  {mode_hi, mode_lo}.
- cmd_state  in  1  current state bit presented to the responder.
- req_en  out  1  responder enable.
- req_mask  out  7  registered request lines.
- req_mode  out  2  registered mode.
- req_state  out  1  registered state bit.
- rsp_hold  in  1  responder hold/next-state bit 1.
- rsp_busy  in  1  responder busy/next-state bit 2.
- rsp_grant  in  1  responder grant.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed.
- res_data  out  3  {grant, busy, hold} at completion.
- res_timeout  out  1  completion forced by timeout.

## Operation
- FIFO: a cmd_valid&cmd_ready cycle pushes {mask, mode, state}. A push and a pop in the same cycle is legal when the FIFO is full. cmd_ready = !full, independent of FSM state.
- FSM states IDLE, DRIVE, SETTLE_W, SAMPLE, RESP.
  - IDLE: if the FIFO is non-empty, pop, load the req_* registers, set req_en=1, go to DRIVE.
  - DRIVE: one cycle. Load settle counter = SETTLE-1. Go to SETTLE_W, or to SAMPLE if SETTLE=1.
  - SETTLE_W: decrement the settle counter; at 0 go to SAMPLE.
  - SAMPLE: capture {rsp_grant, rsp_busy, rsp_hold}.
    - busy=0: go to RESP, res_timeout=0.
    - busy=1 and wait_cnt<TIMEOUT: increment wait_cnt and stay.
    - busy=1 and wait_cnt==TIMEOUT: go to RESP, res_timeout=1.
  - RESP: res_valid=1, with res_data/res_timeout stable. req_en drops on entry, and req_mask/mode/state hold their last values. When res_ready=1, go to IDLE and clear wait_cnt.
- res_valid stays high until accepted; res_data must not change while res_valid=1.
- Reset values: cmd_ready=1 (FIFO empty), req_en=0, req_mask=0, req_mode=0, req_state=0, res_valid=0, res_data=0, res_timeout=0, FSM=IDLE, all counters 0.
- Reset mid-transaction aborts it, drops req_en asynchronously, and discards FIFO contents.

## Timing
- All outputs are registered; no combinational input-to-output path.
- Push at edge N, FIFO empty, FSM IDLE: pop at edge N+1, req_en=1 from N+1, first sample at edge N+1+SETTLE+1.
- Minimum command-to-res_valid latency with SETTLE=1 and no busy: 3 cycles.
- res_valid&res_ready at edge M: the next command (if queued) is driven from edge M+1. Minimum gap between transactions is one IDLE cycle.
- Timeout completion occurs after exactly TIMEOUT+1 busy samples.

## Configuration
- I1_INIT_TIMEOUT_EN defined: timeout counter and res_timeout logic as above.
- Undefined: SAMPLE waits indefinitely while busy, res_timeout is tied 0, and the TIMEOUT parameter is ignored.

## Structure
- Package i1_ctrl_pkg:
  - i1_cmd_t struct {mask[6:0], mode[1:0], state}
  - i1_rsp_t struct {grant, busy, hold}
  - FSM state enum
  - DEFAULT_TIMEOUT constant
- One sub-module: i1_cmd_fifo, a synchronous FIFO of i1_cmd_t, parameterised by depth, with full/empty flags. The FSM, counters and result register live in the top.

## Test plan
The bench uses a behavioural responder model:
- hold = en & (!state | (mask==0 & mode_hi==mode_lo))
- busy = en & ((mask==0 & mode==2'b01) | (state & mask!=0))
- grant = en & mask==0 & !mode_lo

Scenarios:
- Push mask=0, mode=2'b11, state=0; res_ready=1 → res_valid at cycle 3, res_data=3'b001, res_timeout=0.
- Push mask=0, mode=2'b00 → res_data=3'b101 (grant+hold).
- Push mask=0, mode=2'b01, TIMEOUT=15, macro defined → res_valid after 16 busy samples, res_data=3'b011, res_timeout=1. Same push with macro undefined → res_valid stays 0 for 100 cycles.
- Push 5 commands back-to-back with res_ready=0, FIFO_DEPTH=4 → cmd_ready drops after the 5th accepted push (4 buffered + 1 in flight). Releasing res_ready yields 5 results in push order.
- Assert rst during SAMPLE of a busy command → req_en=0 and res_valid=0 immediately; after release cmd_ready=1 and no stale result appears.
- Hold res_ready=0 for 10 cycles in RESP while the responder inputs toggle → res_data is unchanged throughout.

Source files
------------

// File: rtl/i1_ctrl_pkg.sv
// Shared types for the i1 control initiator: command/response records,
// FSM state encoding and the default busy timeout.
package i1_ctrl_pkg;

    typedef struct packed {
        logic [6:0] mask;
        logic [1:0] mode;
        logic       state;
    } i1_cmd_t;

    typedef struct packed {
        logic grant;
        logic busy;
        logic hold;
    } i1_rsp_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE_W,
        ST_SAMPLE,
        ST_RESP
    } i1_state_e;

    localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/i1_cmd_fifo.sv
// Synchronous command FIFO of i1_cmd_t; DEPTH must be a power of two.
// Head entry is presented on rdata whenever the FIFO is non-empty.
module i1_cmd_fifo
    import i1_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  logic    pop,
    input  i1_cmd_t wdata,
    output i1_cmd_t rdata,
    output logic    full,
    output logic    empty
);
    localparam int AW = $clog2(DEPTH);

    i1_cmd_t       mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // a pop frees the slot the same cycle, so a full FIFO can still take a push
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/i1_ctrl_initiator.sv
// Initiating end of the i1 control interface: buffers commands, drives the
// responder request lines and returns each sampled outcome. Optional busy
// timeout is enabled by defining I1_INIT_TIMEOUT_EN.
module i1_ctrl_initiator
    import i1_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SETTLE     = 1,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_mask,
    input  logic [1:0] cmd_mode,
    input  logic       cmd_state,
    output logic       req_en,
    output logic [6:0] req_mask,
    output logic [1:0] req_mode,
    output logic       req_state,
    input  logic       rsp_hold,
    input  logic       rsp_busy,
    input  logic       rsp_grant,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [2:0] res_data,
    output logic       res_timeout
);
    localparam logic [2:0] SETTLE_LD = 3'(SETTLE - 1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        SETTLE < 1 || SETTLE > 7 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_param_check
        $error("i1_ctrl_initiator: parameter out of range");
    end

    i1_state_e  state_q, state_d;
    i1_cmd_t    fifo_head, fifo_wdata;
    i1_rsp_t    rsp_now, res_q;
    logic       fifo_full, fifo_empty;
    logic       pop, cap, timed_out;
    logic [2:0] settle_cnt;

    assign fifo_wdata = '{mask: cmd_mask, mode: cmd_mode, state: cmd_state};
    assign rsp_now    = '{grant: rsp_grant, busy: rsp_busy, hold: rsp_hold};
    assign cmd_ready  = !fifo_full;
    assign res_data   = res_q;

    i1_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid && !fifo_full),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef I1_INIT_TIMEOUT_EN
    localparam logic [7:0] TO_MAX = 8'(TIMEOUT);

    logic [7:0] wait_cnt;
    logic       res_to_q;

    // wait_cnt counts busy samples already taken; the TIMEOUT+1-th one completes
    assign timed_out   = rsp_busy && (wait_cnt == TO_MAX);
    assign res_timeout = res_to_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            res_to_q <= 1'b0;
        end else begin
            if (state_q == ST_SAMPLE && rsp_busy && !timed_out)
                wait_cnt <= wait_cnt + 8'd1;
            else if (state_q == ST_RESP && res_ready)
                wait_cnt <= '0;
            if (cap) res_to_q <= timed_out;
        end
    end
`else
    assign timed_out   = 1'b0;
    assign res_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        cap     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE:    state_d = (SETTLE == 1) ? ST_SAMPLE : ST_SETTLE_W;
            ST_SETTLE_W: if (settle_cnt == 3'd1) state_d = ST_SAMPLE;
            ST_SAMPLE: begin
                if (!rsp_busy || timed_out) begin
                    cap     = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP:     if (res_ready) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_en     <= 1'b0;
            req_mask   <= '0;
            req_mode   <= '0;
            req_state  <= 1'b0;
            settle_cnt <= '0;
            res_valid  <= 1'b0;
            res_q      <= '0;
        end else begin
            if (pop) begin
                req_en    <= 1'b1;
                req_mask  <= fifo_head.mask;
                req_mode  <= fifo_head.mode;
                req_state <= fifo_head.state;
            end
            if (state_q == ST_DRIVE)
                settle_cnt <= SETTLE_LD;
            else if (state_q == ST_SETTLE_W)
                settle_cnt <= settle_cnt - 3'd1;
            // request lines keep their last values through RESP; only enable drops
            if (cap) begin
                req_en    <= 1'b0;
                res_valid <= 1'b1;
                res_q     <= rsp_now;
            end else if (state_q == ST_RESP && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i1_ctrl_initiator.sv
// Self-checking bench for i1_ctrl_initiator with a behavioural responder and
// a result model derived from the responder rules.
module tb_i1_ctrl_initiator;
    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic [6:0] cmd_mask;
    logic [1:0] cmd_mode;
    logic       cmd_state;
    logic       req_en;
    logic [6:0] req_mask;
    logic [1:0] req_mode;
    logic       req_state;
    logic       rsp_hold, rsp_busy, rsp_grant;
    logic       res_valid, res_ready;
    logic [2:0] res_data;
    logic       res_timeout;

    int checks = 0;
    int errors = 0;

    logic       ovr = 1'b0;
    logic [2:0] ovr_val = 3'b000;

    i1_ctrl_initiator #(.FIFO_DEPTH(4), .SETTLE(1), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mask(cmd_mask), .cmd_mode(cmd_mode), .cmd_state(cmd_state),
        .req_en(req_en), .req_mask(req_mask), .req_mode(req_mode), .req_state(req_state),
        .rsp_hold(rsp_hold), .rsp_busy(rsp_busy), .rsp_grant(rsp_grant),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_timeout(res_timeout)
    );

    always #5 clk = ~clk;

    // responder behaviour, with an override used to wiggle its outputs
    always_comb begin
        rsp_grant = 1'b0;
        rsp_busy  = 1'b0;
        rsp_hold  = 1'b0;
        if (ovr) begin
            {rsp_grant, rsp_busy, rsp_hold} = ovr_val;
        end else if (req_en) begin
            rsp_hold  = !req_state || (req_mask == 7'd0 && req_mode[1] == req_mode[0]);
            rsp_busy  = (req_mask == 7'd0 && req_mode == 2'b01) || (req_state && req_mask != 7'd0);
            rsp_grant = (req_mask == 7'd0) && !req_mode[0];
        end
    end

    // expected {timeout, grant, busy, hold} for a command {mask, mode, state}
    function automatic logic [3:0] model(input logic [9:0] c);
        logic [6:0] m;
        logic [1:0] md;
        logic       st, h, b, g;
        m  = c[9:3];
        md = c[2:1];
        st = c[0];
        h  = !st || (m == 7'd0 && md[1] == md[0]);
        b  = (m == 7'd0 && md == 2'b01) || (st && m != 7'd0);
        g  = (m == 7'd0) && !md[0];
`ifdef I1_INIT_TIMEOUT_EN
        return {b, g, b, h};
`else
        return {1'b0, g, b, h};
`endif
    endfunction

    function automatic logic [9:0] rand_cmd();
        logic [9:0] c;
        c = 10'($urandom);
        if ($urandom_range(0, 3) == 0) c[9:3] = 7'd0;
`ifndef I1_INIT_TIMEOUT_EN
        // without a timeout a busy command would never complete
        c[0] = 1'b0;
        if (c[9:3] == 7'd0 && c[2:1] == 2'b01) c[2:1] = 2'b10;
`endif
        return c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [9:0] c);
        chk("cmd_ready_before_push", cmd_ready, 1);
        cmd_valid = 1'b1;
        {cmd_mask, cmd_mode, cmd_state} = c;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(input int limit);
        int n;
        n = 0;
        while (!res_valid && n < limit) begin
            tick();
            n++;
        end
        chk("res_valid_within_bound", res_valid, 1);
    endtask

    task automatic get_result(input logic [9:0] c, input int limit);
        logic [3:0] e;
        e = model(c);
        wait_valid(limit);
        if (res_valid) begin
            chk("res_data", res_data, e[2:0]);
            chk("res_timeout", res_timeout, e[3]);
            chk("req_en_low_in_resp", req_en, 0);
            chk("req_mask_held", req_mask, c[9:3]);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("res_valid_after_accept", res_valid, 0);
    endtask

    initial begin
        logic [9:0] c;
        logic [9:0] q[$];
        logic [3:0] e;
        int         n;
        logic       seen;

        rst = 1'b1;
        cmd_valid = 1'b0;
        {cmd_mask, cmd_mode, cmd_state} = '0;
        res_ready = 1'b0;
        tick(); tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_req_en", req_en, 0);
        chk("rst_req_mask", req_mask, 0);
        chk("rst_req_mode", req_mode, 0);
        chk("rst_req_state", req_state, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_timeout", res_timeout, 0);
        rst = 1'b0;
        tick();

        // minimum latency: valid after the third edge following the push
        res_ready = 1'b1;
        push({7'd0, 2'b11, 1'b0});
        chk("lat_req_en_n0", req_en, 0);
        tick();
        chk("lat_req_en_n1", req_en, 1);
        chk("lat_req_mode_n1", req_mode, 2'b11);
        tick();
        chk("lat_res_valid_n2", res_valid, 0);
        tick();
        chk("lat_res_valid_n3", res_valid, 1);
        chk("lat_res_data", res_data, 3'b001);
        chk("lat_res_timeout", res_timeout, 0);
        tick();
        chk("lat_res_valid_n4", res_valid, 0);
        res_ready = 1'b0;

        c = {7'd0, 2'b00, 1'b0};
        push(c);
        get_result(c, 20);
        chk("grant_hold_model", model(c), 4'b0101);

`ifdef I1_INIT_TIMEOUT_EN
        // timeout after exactly 16 busy samples
        c = {7'd0, 2'b01, 1'b0};
        push(c);
        n = 0;
        while (!res_valid && n < 60) begin
            tick();
            n++;
        end
        chk("timeout_latency", n, 18);
        chk("timeout_res_data", res_data, 3'b011);
        chk("timeout_flag", res_timeout, 1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("timeout_accept", res_valid, 0);
`else
        c = {7'd0, 2'b01, 1'b0};
        push(c);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (res_valid) seen = 1'b1;
        end
        chk("no_timeout_stays_busy", seen, 0);
        chk("no_timeout_req_en", req_en, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
`endif

        // asynchronous reset in the middle of a busy sample phase
        c = {7'h05, 2'b00, 1'b1};
        push(c);
        push(rand_cmd());
        tick(); tick(); tick();
        chk("busy_req_en_before_rst", req_en, 1);
        chk("busy_res_valid_before_rst", res_valid, 0);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_req_en", req_en, 0);
        chk("async_rst_res_valid", res_valid, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_cmd_ready", cmd_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (res_valid || req_en) seen = 1'b1;
        end
        chk("post_rst_no_stale", seen, 0);

        // back-pressure: 4 buffered + 1 in flight fills the path
        q.delete();
        for (int i = 0; i < 5; i++) begin
            c = rand_cmd();
            q.push_back(c);
            push(c);
        end
        chk("full_cmd_ready", cmd_ready, 0);
        while (q.size() > 0) begin
            c = q.pop_front();
            get_result(c, 40);
        end
        chk("drained_cmd_ready", cmd_ready, 1);

        // result must stay frozen while held, whatever the responder does
        c = {7'h12, 2'b10, 1'b0};
        e = model(c);
        push(c);
        wait_valid(20);
        ovr = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ovr_val = 3'($urandom);
            tick();
            if (res_data !== e[2:0] || res_valid !== 1'b1) seen = 1'b1;
        end
        chk("held_res_stable", seen, 0);
        chk("held_res_data", res_data, e[2:0]);
        ovr = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // random commands with random idle gaps before collecting
        for (int i = 0; i < 25; i++) begin
            c = rand_cmd();
            push(c);
            n = $urandom_range(0, 4);
            for (int k = 0; k < n; k++) tick();
            get_result(c, 40);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
